// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the two-port Sysbus read arbiter.
// Sysbus command encodings live here so the whole slice agrees on one definition.
package sysbus_arb_pkg;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int BEATS_DEFAULT    = 8;
  localparam int LINE_OFFSET_BITS = 6;

  localparam int TAG_RW_BIT  = 12;
  localparam int TAG_TGT_MSB = 11;
  localparam int TAG_TGT_LSB = 8;
  localparam int TAG_ID_MSB  = 7;
  localparam int TAG_ID_LSB  = 0;

  // Read-line tag with the requesting port as the transaction ID.
  function automatic logic [12:0] read_tag(input logic owner);
    read_tag = {SYSBUS_READ, SYSBUS_MEMORY, 7'b0000000, owner};
  endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Port-side and bus-side signals of the Sysbus read arbiter.
interface sysbus_arbiter_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          p0_req_valid, p1_req_valid;
  logic [DW-1:0] p0_req_addr, p1_req_addr;
  logic          p0_req_ack, p1_req_ack;
  logic          p0_resp_valid, p1_resp_valid;
  logic          p0_resp_last, p1_resp_last;
  logic [DW-1:0] resp_data;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic          bus_respack;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          tag_err;

  modport master (
    input  p0_req_valid, p1_req_valid, p0_req_addr, p1_req_addr,
           bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output p0_req_ack, p1_req_ack, p0_resp_valid, p1_resp_valid,
           p0_resp_last, p1_resp_last, resp_data, bus_reqcyc, bus_req,
           bus_reqtag, bus_respack, tag_err
  );

  modport slave (
    output p0_req_valid, p1_req_valid, p0_req_addr, p1_req_addr,
           bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  p0_req_ack, p1_req_ack, p0_resp_valid, p1_resp_valid,
           p0_resp_last, p1_resp_last, resp_data, bus_reqcyc, bus_req,
           bus_reqtag, bus_respack, tag_err
  );
endinterface

// File: rtl/sysbus_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the port not granted last time wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // Winner selection from the request pair and previous grant.
  always_comb begin
    grant_valid_o = |req_i;
    case (req_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the Sysbus read channel between fetch (port 0) and data (port 1):
// one line request at a time, response beats routed back to the owning port.
module sysbus_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = BEATS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  sysbus_arbiter_if.master bus_if
);

  localparam int                CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t                state_q;
  logic                      last_grant_q;
  logic                      owner_q;
  logic                      tag_err_q;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                      grant_valid_s;
  logic                      grant_id_s;
  logic                      in_req_s;
  logic                      consume_s;
  logic                      last_beat_s;
  logic                      tag_bad_s;
  logic [BUS_DATA_WIDTH-1:0] win_addr_s;
  logic                      unused_ok_s;

  rr_pick2 u_pick (
    .req_i         ({bus_if.p1_req_valid, bus_if.p0_req_valid}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid_s),
    .grant_id_o    (grant_id_s)
  );

  // Address of the winning port, line-aligned.
  always_comb begin
    if (grant_id_s) begin
      win_addr_s = {bus_if.p1_req_addr[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS],
                    {LINE_OFFSET_BITS{1'b0}}};
    end else begin
      win_addr_s = {bus_if.p0_req_addr[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS],
                    {LINE_OFFSET_BITS{1'b0}}};
    end
  end

  assign in_req_s    = (state_q == REQ);
  assign consume_s   = (state_q == RESP) && bus_if.bus_respcyc;
  assign last_beat_s = consume_s && (cnt_q == LAST_BEAT);
  // Only the ID field is checked; rd/wr and target bits are not owner-specific.
  assign tag_bad_s   = (bus_if.bus_resptag[TAG_ID_MSB:TAG_ID_LSB] != {7'b0000000, owner_q});
  assign unused_ok_s = ^{bus_if.bus_resptag[BUS_TAG_WIDTH-1:TAG_TGT_LSB],
                         bus_if.p0_req_addr[LINE_OFFSET_BITS-1:0],
                         bus_if.p1_req_addr[LINE_OFFSET_BITS-1:0]};

  // Arbitration / request / response-collection state machine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      tag_err_q    <= 1'b0;
      addr_q       <= {BUS_DATA_WIDTH{1'b0}};
      tag_q        <= {BUS_TAG_WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid_s) begin
            addr_q       <= win_addr_s;
            tag_q        <= BUS_TAG_WIDTH'(read_tag(grant_id_s));
            owner_q      <= grant_id_s;
            last_grant_q <= grant_id_s;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (bus_if.bus_reqack) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= RESP;
          end
        end
        RESP: begin
          if (consume_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (tag_bad_s) begin
              tag_err_q <= 1'b1;
            end
            if (last_beat_s) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.bus_reqcyc    = in_req_s;
  assign bus_if.bus_req       = addr_q;
  assign bus_if.bus_reqtag    = tag_q;
  assign bus_if.bus_respack   = consume_s;
  assign bus_if.tag_err       = tag_err_q;
  assign bus_if.p0_req_ack    = in_req_s && bus_if.bus_reqack && !owner_q;
  assign bus_if.p1_req_ack    = in_req_s && bus_if.bus_reqack &&  owner_q;
  assign bus_if.p0_resp_valid = consume_s && !owner_q;
  assign bus_if.p1_resp_valid = consume_s &&  owner_q;
  assign bus_if.p0_resp_last  = last_beat_s && !owner_q;
  assign bus_if.p1_resp_last  = last_beat_s &&  owner_q;
  assign bus_if.resp_data     = consume_s ? bus_if.bus_resp : {BUS_DATA_WIDTH{1'b0}};

endmodule
